// File: rtl/rfsoc_ctrl_pkg.sv
// Shared definitions for the PS-side control/datapath blocks.
// Holds the PL word width, the arbiter state type and the round-robin search helper.
package rfsoc_ctrl_pkg;

  localparam int unsigned PL_WORD_W = 256;
  localparam int unsigned MAX_SRC   = 16;

  typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_PAD} arb_state_t;

  // Returns {hit, index}: first requester after 'last', wrapping modulo num_src.
  function automatic logic [4:0] rr_next(input logic [15:0]   req,
                                         input logic [3:0]    last,
                                         input int unsigned   num_src);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      if (k <= num_src && !res[4]) begin
        idx = (32'(last) + k) % num_src;
        if (req[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin priority search over NUM_SRC requesters.
// The search starts one past the previous grant so a winner cannot repeat while others wait.
module rr_grant_select
  import rfsoc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned CH_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [CH_W-1:0]    last_i,
  output logic               hit_o,
  output logic [CH_W-1:0]    idx_o
);

  logic [4:0] res;

  always_comb begin
    res   = rr_next(16'(req_i), 4'(last_i), NUM_SRC);
    hit_o = res[4];
    idx_o = CH_W'(res[3:0]);
  end

endmodule

// File: rtl/axis_ps_stream_arbiter.sv
// Packet-granular round-robin arbiter onto the single PS AXIS path into the PS-to-PL converter.
// Short packet tails are zero-padded so every packet fills whole PL words.
module axis_ps_stream_arbiter
  import rfsoc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PS_W    = 32,
  localparam int unsigned WPB    = PL_WORD_W / PS_W,
  localparam int unsigned CH_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    ps_clk,
  input  logic                    rst,
  input  logic [NUM_SRC*PS_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]      s_axis_tvalid,
  input  logic [NUM_SRC-1:0]      s_axis_tlast,
  output logic [NUM_SRC-1:0]      s_axis_tready,
  output logic [PS_W-1:0]         m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [CH_W-1:0]         m_axis_tdest,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [CH_W-1:0]         grant_id,
  output logic [15:0]             pad_count
);

  localparam int unsigned CNT_W = (WPB > 1) ? $clog2(WPB) : 1;

  arb_state_t      state_q;
  logic [CH_W-1:0] grant_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [15:0]     pad_cnt_q;

  logic            out_free;
  logic            rr_hit;
  logic [CH_W-1:0] rr_idx;
  logic [PS_W-1:0] sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            hs;
  logic            word_last;
  logic [CNT_W-1:0] word_cnt_nxt;

  rr_grant_select #(
    .NUM_SRC(NUM_SRC)
  ) u_rr_grant_select (
    .req_i (s_axis_tvalid),
    .last_i(grant_q),
    .hit_o (rr_hit),
    .idx_o (rr_idx)
  );

  always_comb begin
    out_free     = !m_axis_tvalid || m_axis_tready;
    sel_data     = s_axis_tdata[grant_q*PS_W +: PS_W];
    sel_valid    = s_axis_tvalid[grant_q];
    sel_last     = s_axis_tlast[grant_q];
    hs           = (state_q == ARB_PASS) && sel_valid && out_free;
    word_last    = (word_cnt_q == CNT_W'(WPB - 1));
    word_cnt_nxt = word_last ? '0 : word_cnt_q + 1'b1;
    s_axis_tready = '0;
    if (state_q == ARB_PASS) s_axis_tready[grant_q] = out_free;
  end

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= CH_W'(NUM_SRC - 1);
      word_cnt_q    <= '0;
      pad_cnt_q     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
          // Arbitration bubble: grant only, no data accepted this cycle.
          if (rr_hit) begin
            grant_q <= rr_idx;
            state_q <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tdest  <= grant_q;
            word_cnt_q    <= word_cnt_nxt;
            m_axis_tlast  <= sel_last && word_last;
            if (sel_last) begin
              if (word_last) begin
                state_q <= ARB_IDLE;
              end else begin
                state_q <= ARB_PAD;
                if (pad_cnt_q != 16'hFFFF) pad_cnt_q <= pad_cnt_q + 16'd1;
              end
            end
          end else if (out_free) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        ARB_PAD: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tdest  <= grant_q;
            m_axis_tlast  <= word_last;
            word_cnt_q    <= word_cnt_nxt;
            if (word_last) state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign grant_id  = grant_q;
  assign pad_count = pad_cnt_q;

endmodule

// File: tb/tb_axis_ps_stream_arbiter.sv
// Directed bench for axis_ps_stream_arbiter: per-source packet feeders, expected beats
// queued at stimulus time and checked as they leave the output port.
module tb_axis_ps_stream_arbiter;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int WPB = 8;

  logic            ps_clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS*W-1:0] s_axis_tdata = '0;
  logic [NS-1:0]   s_axis_tvalid = '0;
  logic [NS-1:0]   s_axis_tlast = '0;
  logic [NS-1:0]   s_axis_tready;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tdest;
  logic            m_axis_tready = 1'b1;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     pad_count;

  axis_ps_stream_arbiter #(
    .NUM_SRC(NS),
    .PS_W   (W)
  ) dut (
    .ps_clk       (ps_clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .grant_id     (grant_id),
    .pad_count    (pad_count)
  );

  always #5 ps_clk = ~ps_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] sb[$];            // {tlast, tdest, tdata}
  logic [32:0] mem[NS][64];      // {tlast, tdata} per source
  int          wr_ptr[NS];
  int          rd_ptr[NS];
  logic [NS-1:0] hs = '0;
  int          hs_cnt2 = 0;
  bit          stall_mode = 1'b0;
  int          stall_phase = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int src, input logic [31:0] base, input int len);
    for (int j = 0; j < len; j++) begin
      mem[src][wr_ptr[src]] = {(j == len - 1), base + 32'(j)};
      wr_ptr[src]++;
    end
  endtask

  task automatic push_pkt(input int src, input logic [31:0] base, input int len);
    int padded;
    padded = ((len + WPB - 1) / WPB) * WPB;
    for (int j = 0; j < padded; j++)
      sb.push_back({(j == padded - 1), 2'(src), (j < len) ? base + 32'(j) : 32'h0});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || m_axis_tvalid) && n < 2000) begin
      @(negedge ps_clk);
      n++;
    end
    chk(tag, {63'h0, (sb.size() == 0 && !busy)}, 64'h1);
  endtask

  // Source feeders: advance on a handshake seen in the previous cycle.
  initial begin
    for (int i = 0; i < NS; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    forever begin
      @(posedge ps_clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) rd_ptr[i]++;
        if (rd_ptr[i] < wr_ptr[i]) begin
          s_axis_tvalid[i]       = 1'b1;
          s_axis_tdata[i*W +: W] = mem[i][rd_ptr[i]][31:0];
          s_axis_tlast[i]        = mem[i][rd_ptr[i]][32];
        end else begin
          s_axis_tvalid[i]       = 1'b0;
          s_axis_tdata[i*W +: W] = '0;
          s_axis_tlast[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge ps_clk);
      hs = s_axis_tvalid & s_axis_tready;
      if (hs[2]) hs_cnt2++;
    end
  end

  initial begin
    forever begin
      @(posedge ps_clk);
      #1;
      if (stall_mode) begin
        m_axis_tready = (stall_phase == 0);
        stall_phase   = (stall_phase + 1) % 3;
      end
    end
  end

  // Output monitor: scoreboard pop, one-hot tready and stall stability.
  initial begin
    logic        prev_stall;
    logic [35:0] prev_beat;
    logic [34:0] exp;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge ps_clk);
      if (rst) begin
        chk("tready_onehot", {63'h0, ($countones(s_axis_tready) <= 1)}, 64'h1);
        if (prev_stall)
          chk("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata}),
              64'(prev_beat));
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'({m_axis_tlast, m_axis_tdest, m_axis_tdata}), 64'hDEAD);
          end else begin
            exp = sb.pop_front();
            chk("beat", 64'({m_axis_tlast, m_axis_tdest, m_axis_tdata}), 64'(exp));
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge ps_clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'h0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'h0);
    chk("rst_tdest", 64'(m_axis_tdest), 64'h0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_grant", 64'(grant_id), 64'h3);
    chk("rst_pad", 64'(pad_count), 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge ps_clk);

    // Single 8-word packet from source 0, plus first-beat latency.
    push_pkt(0, 32'h100, 8);
    send(0, 32'h100, 8);
    n = 0;
    while (!s_axis_tvalid[0] && n < 10) begin @(negedge ps_clk); n++; end
    n = 0;
    while (!m_axis_tvalid && n < 10) begin @(negedge ps_clk); n++; end
    chk("latency", 64'(n), 64'h2);
    wait_done("drain_t1");
    chk("pad_t1", 64'(pad_count), 64'h0);
    chk("grant_t1", 64'(grant_id), 64'h0);

    // Short packet from source 1: padded to a full PL word.
    push_pkt(1, 32'hA, 3);
    send(1, 32'hA, 3);
    wait_done("drain_t2");
    chk("pad_t2", 64'(pad_count), 64'h1);

    // 9-word packet from source 3: 9 data plus 7 zeros.
    push_pkt(3, 32'h300, 9);
    send(3, 32'h300, 9);
    wait_done("drain_t3");
    chk("pad_t3", 64'(pad_count), 64'h2);
    chk("grant_t3", 64'(grant_id), 64'h3);

    // Sources 0,2,3 requesting back to back; last grant was 3 so order is 0,2,3,0,2,3.
    for (int k = 0; k < 2; k++) begin
      push_pkt(0, 32'h4000 + 32'(k * 16), 8);
      push_pkt(2, 32'h6000 + 32'(k * 16), 8);
      push_pkt(3, 32'h7000 + 32'(k * 16), 8);
    end
    for (int k = 0; k < 2; k++) begin
      send(0, 32'h4000 + 32'(k * 16), 8);
      send(2, 32'h6000 + 32'(k * 16), 8);
      send(3, 32'h7000 + 32'(k * 16), 8);
    end
    wait_done("drain_rr");
    chk("pad_rr", 64'(pad_count), 64'h2);
    chk("grant_rr", 64'(grant_id), 64'h3);

    // Downstream stalls in a 1,0,0 pattern.
    stall_mode = 1'b1;
    push_pkt(1, 32'h500, 8);
    send(1, 32'h500, 8);
    wait_done("drain_stall");
    stall_mode    = 1'b0;
    m_axis_tready = 1'b1;
    chk("grant_stall", 64'(grant_id), 64'h1);

    // Reset after four words of a source-2 packet: three beats leave before it hits.
    hs_cnt2 = 0;
    for (int j = 0; j < 3; j++) sb.push_back({1'b0, 2'd2, 32'h600 + 32'(j)});
    send(2, 32'h600, 8);
    n = 0;
    while (hs_cnt2 < 4 && n < 100) begin @(negedge ps_clk); #1; n++; end
    chk("reset_reach", 64'(hs_cnt2), 64'h4);
    @(posedge ps_clk);
    #2;
    rst = 1'b0;
    rd_ptr[2] = wr_ptr[2];
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("mid_rst_tdata", 64'(m_axis_tdata), 64'h0);
    chk("mid_rst_s_tready", 64'(s_axis_tready), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_grant", 64'(grant_id), 64'h3);
    chk("mid_rst_pad", 64'(pad_count), 64'h0);
    chk("mid_rst_sb", 64'(sb.size()), 64'h0);
    repeat (2) @(negedge ps_clk);
    rst = 1'b1;
    @(negedge ps_clk);
    push_pkt(2, 32'h700, 8);
    send(2, 32'h700, 8);
    wait_done("drain_post_rst");
    chk("grant_post_rst", 64'(grant_id), 64'h2);
    chk("pad_post_rst", 64'(pad_count), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
